pe_accumulator: RTL



---
 rtl/pea_pkg.sv | 12 +
 rtl/pe_accumulator.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pea_pkg.sv
// Shared PE array definitions: datapath width and accumulator FSM encoding.
package pea_pkg;

    localparam int N_BITS    = 32;
    localparam int ACC_CNT_W = 8;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/pe_accumulator.sv
// Reduction stage after the PE functional unit: sums acc_len_i consecutive
// accepted results and emits one registered sum per run.
module pe_accumulator #(
    parameter int N_BITS = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [CNT_W-1:0]  acc_len_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    input  logic [N_BITS-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [N_BITS-1:0] out_data_o,
    output logic              acc_ready_o,
    output logic              busy_o,
    output logic              ovf_o
);
    import pea_pkg::*;

    acc_state_t        state_reg, state_next;
    logic [N_BITS-1:0] acc_reg, acc_next;
    logic [N_BITS-1:0] out_data_reg, out_data_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  len_reg, len_next;
    logic              ovf_run_reg, ovf_run_next;
    logic              out_ovf_reg, out_ovf_next;
    logic              out_valid_reg, out_valid_next;

    logic              accept;
    logic [N_BITS-1:0] sum;
    logic              add_ovf;
    logic [CNT_W-1:0]  start_len;
    logic              last_in_run;

    assign accept      = en_i & in_valid_i & ~clear_i;
    assign sum         = acc_reg + in_data_i;
    // Same-sign operands producing an opposite-sign result is a signed overflow.
    assign add_ovf     = (acc_reg[N_BITS-1] == in_data_i[N_BITS-1]) &&
                         (sum[N_BITS-1] != acc_reg[N_BITS-1]);
    assign start_len   = (acc_len_i == '0) ? CNT_W'(1) : acc_len_i;
    assign last_in_run = (cnt_reg + CNT_W'(1)) == len_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ACC_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            len_reg       <= '0;
            ovf_run_reg   <= 1'b0;
            out_ovf_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            len_reg       <= len_next;
            ovf_run_reg   <= ovf_run_next;
            out_ovf_reg   <= out_ovf_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear_i) begin
            state_next = ACC_IDLE;
        end else if (accept) begin
            case (state_reg)
                ACC_IDLE: if (start_len != CNT_W'(1)) state_next = ACC_RUN;
                ACC_RUN:  if (last_in_run) state_next = ACC_IDLE;
                default:  state_next = ACC_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        len_next       = len_reg;
        ovf_run_next   = ovf_run_reg;
        out_valid_next = 1'b0;
        out_data_next  = out_data_reg;
        out_ovf_next   = out_ovf_reg;
        if (clear_i) begin
            acc_next     = '0;
            cnt_next     = '0;
            ovf_run_next = 1'b0;
        end else if (accept) begin
            case (state_reg)
                ACC_IDLE: begin
                    len_next     = start_len;
                    acc_next     = in_data_i;
                    cnt_next     = CNT_W'(1);
                    ovf_run_next = 1'b0;
                    // A single-sample run completes immediately without entering RUN.
                    if (start_len == CNT_W'(1)) begin
                        out_valid_next = 1'b1;
                        out_data_next  = in_data_i;
                        out_ovf_next   = 1'b0;
                    end
                end
                ACC_RUN: begin
                    acc_next     = sum;
                    cnt_next     = cnt_reg + CNT_W'(1);
                    ovf_run_next = ovf_run_reg | add_ovf;
                    if (last_in_run) begin
                        out_valid_next = 1'b1;
                        out_data_next  = sum;
                        out_ovf_next   = ovf_run_reg | add_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid_o = out_valid_reg;
    assign acc_ready_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign ovf_o       = out_ovf_reg;
    assign busy_o      = (state_reg == ACC_RUN);

endmodule
